// File: rtl/sprite_frame_scheduler.sv
// Per frame tick: erase every sprite at its previous position, then redraw at the new one, one pixel per cycle (mirroring via SPR_FLIP_EN).
// Fixed latency: busy for 2*NUM_SPRITES*SPR_W*SPR_H+1 cycles; no backpressure, ticks while busy are dropped and flagged.
module sprite_frame_scheduler #(
  parameter int NUM_SPRITES = 6,
  parameter int SPR_W       = 8,
  parameter int SPR_H       = 8,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOUR_W    = 3,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int BG_COLOUR   = 0
) (
  input  logic                            CLOCK_50,
  input  logic                            reset,
  input  logic                            frame_tick,
  input  logic [NUM_SPRITES-1:0]          spr_en,
  input  logic [NUM_SPRITES*X_W-1:0]      spr_x,
  input  logic [NUM_SPRITES*Y_W-1:0]      spr_y,
  input  logic [NUM_SPRITES*COLOUR_W-1:0] spr_colour,
  input  logic [SPR_W*SPR_H-1:0]          spr_mask,
`ifdef SPR_FLIP_EN
  input  logic [NUM_SPRITES-1:0]          spr_flip,
`endif
  output logic [X_W-1:0]                  x_out,
  output logic [Y_W-1:0]                  y_out,
  output logic [COLOUR_W-1:0]             colour_out,
  output logic                            plot,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            overrun
);

  localparam int P  = SPR_W * SPR_H;
  localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int MW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  state_t          state, nxt_state;
  logic [IW-1:0]   cur_i, nxt_i;
  logic [RW-1:0]   cur_r, nxt_r;
  logic [CW-1:0]   cur_c, nxt_c;

  logic [NUM_SPRITES-1:0] old_en, new_en;
  logic [X_W-1:0]         old_x [NUM_SPRITES];
  logic [X_W-1:0]         new_x [NUM_SPRITES];
  logic [Y_W-1:0]         old_y [NUM_SPRITES];
  logic [Y_W-1:0]         new_y [NUM_SPRITES];
  logic [COLOUR_W-1:0]    new_colour [NUM_SPRITES];
`ifdef SPR_FLIP_EN
  logic [NUM_SPRITES-1:0] old_flip, new_flip;
`endif

  // The counters name the pixel currently on the outputs; nxt_* is the pixel registered at the next edge.
  always_comb begin
    nxt_state = state;
    nxt_i     = cur_i;
    nxt_r     = cur_r;
    nxt_c     = cur_c;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          nxt_state = ERASE;
          nxt_i     = '0;
          nxt_r     = '0;
          nxt_c     = '0;
        end
      end
      ERASE, DRAW: begin
        if (cur_c != CW'(SPR_W - 1)) begin
          nxt_c = cur_c + 1'b1;
        end else begin
          nxt_c = '0;
          if (cur_r != RW'(SPR_H - 1)) begin
            nxt_r = cur_r + 1'b1;
          end else begin
            nxt_r = '0;
            if (cur_i != IW'(NUM_SPRITES - 1)) begin
              nxt_i = cur_i + 1'b1;
            end else begin
              nxt_i     = '0;
              nxt_state = (state == ERASE) ? DRAW : DONE;
            end
          end
        end
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  logic                sel_en, sel_flip, nxt_plot;
  logic [X_W-1:0]      sel_x;
  logic [Y_W-1:0]      sel_y;
  logic [COLOUR_W-1:0] sel_col;
  logic [CW-1:0]       mask_c;
  logic [MW-1:0]       mask_idx;
  logic [X_W:0]        px;
  logic [Y_W:0]        py;

  always_comb begin
    sel_flip = 1'b0;
    if (nxt_state == DRAW) begin
      sel_en  = new_en[nxt_i];
      sel_x   = new_x[nxt_i];
      sel_y   = new_y[nxt_i];
      sel_col = new_colour[nxt_i];
`ifdef SPR_FLIP_EN
      sel_flip = new_flip[nxt_i];
`endif
    end else begin
      sel_en  = old_en[nxt_i];
      sel_x   = old_x[nxt_i];
      sel_y   = old_y[nxt_i];
      sel_col = COLOUR_W'(BG_COLOUR);
`ifdef SPR_FLIP_EN
      sel_flip = old_flip[nxt_i];
`endif
    end
    mask_c   = sel_flip ? (CW'(SPR_W - 1) - nxt_c) : nxt_c;
    mask_idx = MW'(nxt_r * SPR_W) + MW'(mask_c);
    // Computed one bit wider so the clip test sees the true coordinate.
    px       = {1'b0, sel_x} + (X_W+1)'(nxt_c);
    py       = {1'b0, sel_y} + (Y_W+1)'(nxt_r);
    nxt_plot = (nxt_state == ERASE || nxt_state == DRAW) && sel_en && spr_mask[mask_idx] &&
               (px < (X_W+1)'(SCREEN_W)) && (py < (Y_W+1)'(SCREEN_H));
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cur_i      <= '0;
      cur_r      <= '0;
      cur_c      <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      old_en     <= '0;
      new_en     <= '0;
`ifdef SPR_FLIP_EN
      old_flip   <= '0;
      new_flip   <= '0;
`endif
      for (int k = 0; k < NUM_SPRITES; k++) begin
        old_x[k]      <= '0;
        old_y[k]      <= '0;
        new_x[k]      <= '0;
        new_y[k]      <= '0;
        new_colour[k] <= '0;
      end
    end else begin
      state <= nxt_state;
      cur_i <= nxt_i;
      cur_r <= nxt_r;
      cur_c <= nxt_c;
      if (state == IDLE && frame_tick) begin
        new_en <= spr_en;
`ifdef SPR_FLIP_EN
        new_flip <= spr_flip;
`endif
        for (int k = 0; k < NUM_SPRITES; k++) begin
          new_x[k]      <= spr_x[k*X_W +: X_W];
          new_y[k]      <= spr_y[k*Y_W +: Y_W];
          new_colour[k] <= spr_colour[k*COLOUR_W +: COLOUR_W];
        end
      end
      if (state != IDLE && frame_tick) overrun <= 1'b1;
      if (state == DONE) begin
        old_en <= new_en;
        old_x  <= new_x;
        old_y  <= new_y;
`ifdef SPR_FLIP_EN
        old_flip <= new_flip;
`endif
      end
      busy       <= (nxt_state != IDLE);
      frame_done <= (nxt_state == DONE);
      plot       <= nxt_plot;
      if (nxt_state == ERASE || nxt_state == DRAW) begin
        x_out      <= px[X_W-1:0];
        y_out      <= py[Y_W-1:0];
        colour_out <= sel_col;
      end
    end
  end

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Random and directed frames checked against a pixel-list model of the erase/redraw schedule.
module tb_sprite_frame_scheduler;
  localparam int N = 6, SW = 8, SH = 8, XW = 8, YW = 7, CW = 3;
  localparam int P = SW * SH;
  localparam int FRAME = 2 * N * P + 1;

  logic            CLOCK_50 = 1'b0;
  logic            reset = 1'b0;
  logic            frame_tick = 1'b0;
  logic [N-1:0]    spr_en = '0;
  logic [N*XW-1:0] spr_x = '0;
  logic [N*YW-1:0] spr_y = '0;
  logic [N*CW-1:0] spr_colour = '0;
  logic [P-1:0]    spr_mask = '0;
`ifdef SPR_FLIP_EN
  logic [N-1:0]    spr_flip = '0;
`endif
  logic [XW-1:0]   x_out;
  logic [YW-1:0]   y_out;
  logic [CW-1:0]   colour_out;
  logic            plot, busy, frame_done, overrun;

  always #10 CLOCK_50 = ~CLOCK_50;

  sprite_frame_scheduler dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .frame_tick(frame_tick),
    .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y), .spr_colour(spr_colour),
    .spr_mask(spr_mask),
`ifdef SPR_FLIP_EN
    .spr_flip(spr_flip),
`endif
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .plot(plot), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Model: what was last drawn (o_*), what the next frame draws (n_*), and the mask.
  int o_en[N], o_x[N], o_y[N], o_fl[N];
  int n_en[N], n_x[N], n_y[N], n_c[N], n_fl[N];
  logic [P-1:0] m_mask;
  int m_ovr = 0;
  int ex[$], ey[$], ec[$], et[$];

  task automatic add_phase(input int ph);
    int en, bx, by, col, fl, b;
    for (int i = 0; i < N; i++) begin
      if (ph == 0) begin en = o_en[i]; bx = o_x[i]; by = o_y[i]; col = 0;      fl = o_fl[i]; end
      else         begin en = n_en[i]; bx = n_x[i]; by = n_y[i]; col = n_c[i]; fl = n_fl[i]; end
      for (int r = 0; r < SH; r++)
        for (int c = 0; c < SW; c++) begin
          b = r * SW + ((fl != 0) ? (SW - 1 - c) : c);
          if (en != 0 && m_mask[b] && bx + c < 160 && by + r < 120) begin
            ex.push_back(bx + c);
            ey.push_back(by + r);
            ec.push_back(col);
            et.push_back(ph * N * P + i * P + r * SW + c + 1);
          end
        end
    end
  endtask

  task automatic drive_inputs();
    spr_mask = m_mask;
    for (int i = 0; i < N; i++) begin
      spr_en[i]            = (n_en[i] != 0);
      spr_x[i*XW +: XW]    = XW'(n_x[i]);
      spr_y[i*YW +: YW]    = YW'(n_y[i]);
      spr_colour[i*CW +: CW] = CW'(n_c[i]);
`ifdef SPR_FLIP_EN
      spr_flip[i]          = (n_fl[i] != 0);
`endif
    end
  endtask

  task automatic scramble_inputs();
    spr_en     = N'($urandom);
    spr_x      = {$urandom, $urandom};
    spr_y      = {$urandom, $urandom};
    spr_colour = N*CW'($urandom);
`ifdef SPR_FLIP_EN
    spr_flip   = N'($urandom);
`endif
  endtask

  task automatic clear_sprites();
    for (int i = 0; i < N; i++) begin
      n_en[i] = 0; n_x[i] = 0; n_y[i] = 0; n_c[i] = 0; n_fl[i] = 0;
    end
  endtask

  task automatic random_sprites();
    for (int i = 0; i < N; i++) begin
      n_en[i] = int'($urandom_range(0, 3) != 0);
      n_x[i]  = int'($urandom_range(0, 170));
      n_y[i]  = int'($urandom_range(0, 125));
      n_c[i]  = int'($urandom_range(0, 7));
`ifdef SPR_FLIP_EN
      n_fl[i] = int'($urandom_range(0, 1));
`endif
    end
  endtask

  task automatic run_frame(input int inject_at, input int abort_at, output int draws, output int erases);
    int cyc, k, done_at;
    bit aborted;
    cyc = 0; k = 0; done_at = -1; draws = 0; erases = 0; aborted = 0;
    ex.delete(); ey.delete(); ec.delete(); et.delete();
    add_phase(0);
    add_phase(1);
    @(negedge CLOCK_50);
    drive_inputs();
    frame_tick = 1'b1;
    @(negedge CLOCK_50);
    frame_tick = 1'b0;
    scramble_inputs();
    for (int t = 0; t < FRAME + 50; t++) begin
      if (!busy) break;
      cyc++;
      if (plot) begin
        if (cyc > N * P) draws++; else erases++;
        if (k < ex.size()) begin
          check("pix_x", int'(x_out), ex[k]);
          check("pix_y", int'(y_out), ey[k]);
          check("pix_colour", int'(colour_out), ec[k]);
          check("pix_cycle", cyc, et[k]);
        end
        k++;
      end
      if (frame_done) done_at = cyc;
      frame_tick = (cyc == inject_at);
      if (cyc == inject_at) m_ovr = 1;
      if (cyc == abort_at) begin
        reset = 1'b0;
        #1;
        check("abort_plot", int'(plot), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_x", int'(x_out), 0);
        aborted = 1;
        break;
      end
      @(negedge CLOCK_50);
    end
    frame_tick = 1'b0;
    if (aborted) begin
      @(negedge CLOCK_50);
      reset = 1'b1;
      m_ovr = 0;
      for (int i = 0; i < N; i++) begin o_en[i] = 0; o_x[i] = 0; o_y[i] = 0; o_fl[i] = 0; end
      check("abort_overrun", int'(overrun), 0);
    end else begin
      check("busy_len", cyc, FRAME);
      check("done_at", done_at, FRAME);
      check("plot_count", k, ex.size());
      check("busy_end", int'(busy), 0);
      check("done_low", int'(frame_done), 0);
      check("overrun", int'(overrun), m_ovr);
      for (int i = 0; i < N; i++) begin
        o_en[i] = n_en[i]; o_x[i] = n_x[i]; o_y[i] = n_y[i]; o_fl[i] = n_fl[i];
      end
    end
  endtask

  int d, e;

  initial begin
    clear_sprites();
    for (int i = 0; i < N; i++) begin o_en[i] = 0; o_x[i] = 0; o_y[i] = 0; o_fl[i] = 0; end
    m_mask = '1;
    repeat (3) @(negedge CLOCK_50);
    check("rst_x", int'(x_out), 0);
    check("rst_y", int'(y_out), 0);
    check("rst_colour", int'(colour_out), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_overrun", int'(overrun), 0);
    reset = 1'b1;

    // Single sprite, first frame: nothing to erase.
    n_en[0] = 1; n_x[0] = 10; n_y[0] = 20; n_c[0] = 7;
    run_frame(0, 0, d, e);
    check("first_draws", d, 64);
    check("first_erases", e, 0);

    n_x[0] = 11;
    run_frame(0, 0, d, e);
    check("move_erases", e, 64);
    check("move_draws", d, 64);

    // Bottom-right corner clipping.
    n_x[0] = 156; n_y[0] = 116;
    run_frame(0, 0, d, e);
    check("corner_draws", d, 16);

    for (int f = 0; f < 4; f++) begin
      m_mask = {$urandom, $urandom};
      random_sprites();
      run_frame(0, 0, d, e);
    end

    // Tick while busy, then confirm overrun stays sticky.
    random_sprites();
    run_frame(100, 0, d, e);
    random_sprites();
    run_frame(0, 0, d, e);

    // Reset during the draw of sprite 3.
    m_mask = '1;
    for (int i = 0; i < N; i++) begin n_en[i] = 1; n_x[i] = 20 * i; n_y[i] = 5 * i; n_c[i] = i + 1; n_fl[i] = 0; end
    run_frame(0, N * P + 3 * P + 5, d, e);
    run_frame(0, 0, d, e);
    check("post_abort_erases", e, 0);

    // Single opaque mask bit at row 1, column 1.
    clear_sprites();
    m_mask = '0;
    m_mask[9] = 1'b1;
    n_en[0] = 1; n_x[0] = 40; n_y[0] = 30; n_c[0] = 5;
    run_frame(0, 0, d, e);
    check("bit9_draws", d, 1);
`ifdef SPR_FLIP_EN
    n_fl[0] = 1;
    run_frame(0, 0, d, e);
    check("flip_draws", d, 1);
    n_fl[0] = 0;
    run_frame(0, 0, d, e);
    check("flip_erases", e, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sprite_frame_scheduler.md
Name: sprite_frame_scheduler

Overview:
- Generalised multi-sprite erase/redraw engine for the 160x120 VGA framebuffer path.
- On each frame tick it erases every sprite at its previous-frame position, then draws every sprite at its new position.
- Pixels are streamed one per cycle as x/y/colour/plot into the VGA adapter.
- Replaces the fixed 6-bird hand-sequenced FSM with a parametrised sprite count, a bitmap mask, per-sprite colour and enable, and screen clipping.

Parameters:
- NUM_SPRITES, 6, number of sprite channels.
- SPR_W, 8, sprite bitmap width in pixels.
- SPR_H, 8, sprite bitmap height in pixels.
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COLOUR_W, 3, colour width.
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are clipped.
- BG_COLOUR, 0, colour used for erase.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  single-cycle frame start pulse.
- spr_en  in  NUM_SPRITES  per-sprite visible flag.
- spr_x  in  NUM_SPRITES*X_W  packed top-left x; sprite i occupies bits [i*X_W +: X_W].
- spr_y  in  NUM_SPRITES*Y_W  packed top-left y.
- spr_colour  in  NUM_SPRITES*COLOUR_W  packed draw colour.
- spr_mask  in  SPR_W*SPR_H  shared bitmap, row-major; bit r*SPR_W+c is pixel (row r, col c); 1 = opaque.
- x_out  out  X_W  pixel x.
- y_out  out  Y_W  pixel y.
- colour_out  out  COLOUR_W  pixel colour.
- plot  out  1  write strobe for the current pixel.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at end of frame.
- overrun  out  1  sticky: a tick arrived while busy.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; x_out=y_out=colour_out=0; plot=busy=frame_done=overrun=0.
  - Previous-frame shadow registers (old_en/old_x/old_y) = 0.
- IDLE, frame_tick=1 sampled at edge k:
  - Latch spr_en/x/y/colour into new_* registers.
  - Enter ERASE with sprite index i=0 and pixel index p=0.
  - Inputs may change after edge k without affecting the frame.
- Sequencing: P = SPR_W*SPR_H.
  - ERASE visits every sprite i=0..N-1, each for exactly P cycles, p scanning row-major (c fastest).
  - Then DRAW visits i=0..N-1 the same way, then one DONE cycle, then IDLE.
  - Timing is deterministic: busy=1 for exactly 2*N*P+1 cycles starting the cycle after edge k.
  - Disabled sprites still consume P cycles with plot=0.
- Per cycle, outputs are registered and present pixel (i,p):
  - x_out = base_x + c, y_out = base_y + r, computed at X_W+1 / Y_W+1 bits; no wrap.
  - plot=1 iff the sprite's enable is set, AND mask bit p=1, AND x < SCREEN_W, AND y < SCREEN_H.
  - Clipped or masked pixels drive plot=0; x/y are still the truncated values.
  - ERASE uses old_en/old_x/old_y with colour_out=BG_COLOUR.
  - DRAW uses new_en/new_x/new_y with colour_out=new_colour[i].
- DONE: old_* <= new_*; frame_done=1 for exactly this cycle; busy still 1. busy falls in the next cycle.
- Erase and draw order:
  - All erases precede all draws, so overlapping sprites are never left with holes.
  - Among draws, higher index wins overlaps.
- The first frame after reset has old_en=0, so ERASE produces no plots.
- frame_tick while busy (including the DONE cycle): ignored, overrun<=1; overrun stays 1 until reset.
- Reset mid-frame: outputs clear immediately; the frame is aborted; old_* are cleared, so the next frame erases nothing.
- Mask changes between frames are not tracked: erase uses the mask present during the erase phase.

Optional Feature:
- Macro SPR_FLIP_EN.
- Defined:
  - Adds port spr_flip in NUM_SPRITES plus old_flip/new_flip shadow registers latched alongside position.
  - When a sprite's flip bit is set, column c uses mask bit r*SPR_W+(SPR_W-1-c) while x_out = base_x + c, mirroring the sprite for flight direction.
  - ERASE uses old_flip.
- Undefined: the port and registers are absent; no mirroring.

Test Plan (defaults: N=6, P=64, frame = 769 busy cycles):
- Reset, then tick with only sprite 0 enabled at (10,20), mask all ones, colour 7 -> 384 cycles with plot=0, then 64 plots covering x 10..17, y 20..27, colour 7; frame_done at busy cycle 769; busy low next cycle.
- Second tick with sprite 0 at (11,20) -> 64 erase plots at x 10..17, colour 0, all before any draw; then 64 draw plots at x 11..18.
- Sprite at (156,116), mask all ones -> exactly 16 draw plots, x 156..159, y 116..119; no plot with x>=160 or y>=120.
- Tick pulsed 100 cycles into a frame -> frame length unchanged (769); overrun=1 and stays 1 through later frames until reset.
- Reset asserted during DRAW of sprite 3 -> plot/busy drop without waiting for a clock edge; next frame shows 0 erase plots.
- Mask with only bit 9 set, sprite at (40,30) -> single draw plot at (41,31); with SPR_FLIP_EN and flip=1 -> single plot at (46,31), and next-frame erase at (46,31).
